// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI Control Change scheduler.
package midi_pkg;

    localparam logic [3:0] MIDI_CC_STATUS = 4'hB;

    typedef logic [7:0] midi_byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND_STATUS,
        ST_SEND_D1,
        ST_SEND_D2
    } cc_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first pending index at or after rr_ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  pending,
    input  logic [IW-1:0] rr_ptr,
    output logic [IW-1:0] grant,
    output logic          grant_vld
);

    // Scan from the farthest offset down so the nearest pending requester is written last and wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr) + k) % N;
            if (pending[idx]) begin
                grant     = IW'(idx);
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/midi_cc_scheduler.sv
// Latches per-requester CC requests and serialises them, round-robin, as
// status/data1/data2 bytes over a valid/ready byte handshake.
module midi_cc_scheduler
    import midi_pkg::*;
#(
    parameter int         NUM_REQ        = 4,
    parameter logic [3:0] CHANNEL        = 4'h0,
    parameter logic [6:0] FIRST_CC       = 7'd46,
    parameter bit         RUNNING_STATUS = 1'b0,
    localparam int        IW             = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [7*NUM_REQ-1:0] req_value,
    output midi_byte_t           tx_byte,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [IW-1:0]        grant_id,
    output logic                 msg_done
);

    cc_sched_state_t state, state_next;
    logic [NUM_REQ-1:0] pending, grant_clr;
    logic [6:0]         value_q [NUM_REQ];
    logic [IW-1:0]      rr_ptr, arb_grant;
    logic               arb_vld;
    midi_byte_t         status_q, d1_q, d2_q, last_status;
    logic               last_status_vld;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .pending   (pending),
        .rr_ptr    (rr_ptr),
        .grant     (arb_grant),
        .grant_vld (arb_vld)
    );

    assign busy = (state != ST_IDLE);

    // Handshake: a byte transfers on tx_valid && tx_ready; while waiting, tx_valid
    // stays high and tx_byte stays fixed because both depend only on registered state.
    always_comb begin
        state_next = state;
        tx_valid   = 1'b0;
        tx_byte    = 8'h00;
        grant_clr  = '0;
        case (state)
            ST_IDLE: begin
                if (arb_vld) begin
                    grant_clr[arb_grant] = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (RUNNING_STATUS && last_status_vld && (last_status == status_q))
                    state_next = ST_SEND_D1;
                else
                    state_next = ST_SEND_STATUS;
            end
            ST_SEND_STATUS: begin
                tx_valid = 1'b1;
                tx_byte  = status_q;
                if (tx_ready) state_next = ST_SEND_D1;
            end
            ST_SEND_D1: begin
                tx_valid = 1'b1;
                tx_byte  = d1_q;
                if (tx_ready) state_next = ST_SEND_D2;
            end
            ST_SEND_D2: begin
                tx_valid = 1'b1;
                tx_byte  = d2_q;
                if (tx_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            pending         <= '0;
            rr_ptr          <= '0;
            grant_id        <= '0;
            msg_done        <= 1'b0;
            status_q        <= 8'h00;
            d1_q            <= 8'h00;
            d2_q            <= 8'h00;
            last_status     <= 8'h00;
            last_status_vld <= 1'b0;
        end else begin
            state    <= state_next;
            msg_done <= (state == ST_SEND_D2) && tx_ready;
            // A re-request arriving on the grant edge survives the clear.
            pending  <= (pending & ~grant_clr) | req;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i]) value_q[i] <= req_value[7*i +: 7];
            end
            if (state == ST_IDLE && arb_vld) begin
                grant_id <= arb_grant;
                status_q <= {MIDI_CC_STATUS, CHANNEL};
                d1_q     <= {1'b0, FIRST_CC + 7'(arb_grant)};
                d2_q     <= {1'b0, value_q[arb_grant]};
                rr_ptr   <= (int'(arb_grant) == NUM_REQ - 1) ? '0 : arb_grant + IW'(1);
            end
            if (state == ST_SEND_STATUS && tx_ready) begin
                last_status     <= status_q;
                last_status_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_midi_cc_scheduler.sv
// Randomised scoreboard bench for midi_cc_scheduler, one instance without and one with running status.
module tb_midi_cc_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [27:0] req_value = '0;
    logic        tx_ready = 1'b0;

    logic [7:0] tx_byte0, tx_byte1;
    logic       tx_valid0, tx_valid1, busy0, busy1, msg_done0, msg_done1;
    logic [1:0] grant_id0, grant_id1;

    int total = 0;
    int bad   = 0;

    // Reference model state, index 0 = plain, index 1 = running status.
    logic [7:0] exp_q0[$], exp_q1[$];
    logic [1:0] done_q0[$], done_q1[$];
    logic [3:0] m_pend[2];
    logic [6:0] m_val[2][4];
    int         m_rr[2], m_phase[2], m_pos[2], m_grant[2];
    bit         m_last_vld[2];
    logic [7:0] m_msg[2][3];
    int         g;

    always #5 clk = ~clk;

    midi_cc_scheduler #(.NUM_REQ(4), .CHANNEL(4'h0), .FIRST_CC(7'd46), .RUNNING_STATUS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .req_value(req_value),
        .tx_byte(tx_byte0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
        .busy(busy0), .grant_id(grant_id0), .msg_done(msg_done0)
    );

    midi_cc_scheduler #(.NUM_REQ(4), .CHANNEL(4'h0), .FIRST_CC(7'd46), .RUNNING_STATUS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .req_value(req_value),
        .tx_byte(tx_byte1), .tx_valid(tx_valid1), .tx_ready(tx_ready),
        .busy(busy1), .grant_id(grant_id1), .msg_done(msg_done1)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic push_byte(input int d, input logic [7:0] b);
        if (d == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
    endtask

    task automatic push_done(input int d, input logic [1:0] gid);
        if (d == 0) done_q0.push_back(gid);
        else        done_q1.push_back(gid);
    endtask

    // Behavioural model: pending set plus a byte list per message, advanced once per clock.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_pend[d] = '0; m_rr[d] = 0; m_phase[d] = 0; m_grant[d] = 0; m_last_vld[d] = 0;
                if (d == 0) begin exp_q0.delete(); done_q0.delete(); end
                else        begin exp_q1.delete(); done_q1.delete(); end
            end else begin
                case (m_phase[d])
                    0: if (m_pend[d] != 0) begin
                        g = -1;
                        for (int k = 0; k < 4; k++)
                            if (g < 0 && m_pend[d][(m_rr[d] + k) % 4]) g = (m_rr[d] + k) % 4;
                        m_msg[d][0] = 8'hB0;
                        m_msg[d][1] = 8'((46 + g) % 128);
                        m_msg[d][2] = {1'b0, m_val[d][g]};
                        m_pend[d][g] = 1'b0;
                        m_rr[d] = (g + 1) % 4;
                        m_grant[d] = g;
                        m_phase[d] = 1;
                    end
                    1: begin
                        m_pos[d] = (d == 1 && m_last_vld[d]) ? 1 : 0;
                        m_phase[d] = 2;
                        push_byte(d, m_msg[d][m_pos[d]]);
                    end
                    default: if (tx_ready) begin
                        if (m_pos[d] == 0) m_last_vld[d] = 1;
                        m_pos[d]++;
                        if (m_pos[d] == 3) begin
                            m_phase[d] = 0;
                            push_done(d, 2'(m_grant[d]));
                        end else begin
                            push_byte(d, m_msg[d][m_pos[d]]);
                        end
                    end
                endcase
                for (int i = 0; i < 4; i++) begin
                    if (req[i]) begin
                        m_pend[d][i] = 1'b1;
                        m_val[d][i]  = req_value[7*i +: 7];
                    end
                end
            end
        end
    end

    task automatic monitor_dut(input int d, input logic [7:0] b, input logic v, input logic bz,
                               input logic [1:0] gid, input logic md);
        logic [7:0] e;
        logic [1:0] eg;
        int n;
        check($sformatf("busy%0d", d), bz, m_phase[d] != 0);
        check($sformatf("tx_valid%0d", d), v, m_phase[d] == 2);
        if (bz) check($sformatf("grant_id%0d", d), gid, m_grant[d]);
        if (v) begin
            n = (d == 0) ? exp_q0.size() : exp_q1.size();
            if (n == 0) check($sformatf("tx_valid_unexpected%0d", d), v, 0);
            else begin
                e = (d == 0) ? exp_q0[0] : exp_q1[0];
                check($sformatf("tx_byte%0d", d), b, e);
                if (tx_ready) begin
                    if (d == 0) void'(exp_q0.pop_front());
                    else        void'(exp_q1.pop_front());
                end
            end
        end
        if (md) begin
            n = (d == 0) ? done_q0.size() : done_q1.size();
            if (n == 0) check($sformatf("msg_done_unexpected%0d", d), md, 0);
            else begin
                eg = (d == 0) ? done_q0.pop_front() : done_q1.pop_front();
                check($sformatf("done_grant%0d", d), gid, eg);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            monitor_dut(0, tx_byte0, tx_valid0, busy0, grant_id0, msg_done0);
            monitor_dut(1, tx_byte1, tx_valid1, busy1, grant_id1, msg_done1);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_byte0"}, tx_byte0, 8'h00);
        check({tag, "_tx_valid0"}, tx_valid0, 0);
        check({tag, "_busy0"}, busy0, 0);
        check({tag, "_grant_id0"}, grant_id0, 0);
        check({tag, "_msg_done0"}, msg_done0, 0);
        check({tag, "_tx_byte1"}, tx_byte1, 8'h00);
        check({tag, "_tx_valid1"}, tx_valid1, 0);
        check({tag, "_busy1"}, busy1, 0);
    endtask

    initial begin
        int waited;
        tx_ready = 1'b1;
        repeat (3) cyc();
        check_reset_outputs("reset");
        rst = 1'b0;
        cyc();

        // Single request on requester 0, value 7F.
        req_value[6:0] = 7'h7F; req = 4'b0001; cyc();
        req = '0; repeat (10) cyc();

        // Simultaneous requests on 1 and 3.
        req_value[13:7] = 7'h15; req_value[27:21] = 7'h2A; req = 4'b1010; cyc();
        req = '0; repeat (15) cyc();

        // Backpressure while data1 (8'h2E) is on the line.
        req_value[6:0] = 7'h05; req = 4'b0001; cyc();
        req = '0; repeat (3) cyc();
        tx_ready = 1'b0;
        repeat (10) cyc();
        check("bp_byte_hold", tx_byte0, 8'h2E);
        check("bp_valid_hold", tx_valid0, 1);
        repeat (10) cyc();
        tx_ready = 1'b1;
        repeat (10) cyc();

        // Reset in the middle of a message with requester 2 still pending.
        req_value[13:7] = 7'h11; req_value[20:14] = 7'h22; req = 4'b0110; cyc();
        req = '0; repeat (3) cyc();
        tx_ready = 1'b0; repeat (2) cyc();
        rst = 1'b1; req = 4'b0100; cyc();
        check_reset_outputs("midrst");
        rst = 1'b0; req = '0; tx_ready = 1'b1;
        repeat (15) cyc();

        // Fairness: requester 0 hammered, requester 1 pulsed once.
        for (int c = 0; c < 30; c++) begin
            req_value = 28'($urandom);
            req = (c == 1) ? 4'b0011 : 4'b0001;
            cyc();
        end
        req = '0; repeat (20) cyc();

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            req_value = 28'($urandom);
            req = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            tx_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end

        // Drain with a bounded wait.
        req = '0; tx_ready = 1'b1;
        waited = 0;
        while (waited < 200 && (busy0 || busy1 || exp_q0.size() != 0 || exp_q1.size() != 0
               || done_q0.size() != 0 || done_q1.size() != 0)) begin
            cyc();
            waited++;
        end
        check("drain_exp_q0", exp_q0.size(), 0);
        check("drain_exp_q1", exp_q1.size(), 0);
        check("drain_done_q0", done_q0.size(), 0);
        check("drain_done_q1", done_q1.size(), 0);
        check("drain_idle", {busy0, busy1}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
